music_sequencer: RTL and testbench

- Downstream consumer of the current-song state machine's `select[1:0]` and `start`.
- Walks the note words of the selected song in the music ROM: presents an address, loads note code and duration, and holds the note on `note` for `duration × TICK_DIV` clocks.
- Detects the end-of-song marker, then loops or stops.
- Feeds the tone generator.

---
 rtl/music_sequencer.sv | 162 ++++++++++++++++
 tb/tb_music_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// Song note sequencer: walks {select, index} through the music ROM and holds each
// note for duration x TICK_DIV clocks, looping or stopping at the end of the song.
module music_sequencer #(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned NOTE_W   = 4,
  parameter int unsigned DUR_W    = 4,
  parameter int unsigned TICK_DIV = 12500000,
  parameter bit          LOOP     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              select,
  input  logic                    start,
  input  logic                    pause,
  output logic [IDX_W+1:0]        mem_addr,
  input  logic [NOTE_W+DUR_W-1:0] mem_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    playing,
  output logic                    song_end
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StEnd} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [NOTE_W-1:0]   code_q, code_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                playing_q, playing_d;
  logic                song_end_q, song_end_d;

  logic [NOTE_W-1:0]   word_code;
  logic [DUR_W-1:0]    word_dur;
  logic                last_idx;
  logic                tick_wrap;
  logic                note_done;

  assign word_code = mem_data[NOTE_W+DUR_W-1:DUR_W];
  assign word_dur  = mem_data[DUR_W-1:0];
  assign last_idx  = (index_q == {IDX_W{1'b1}});
  assign tick_wrap = (state_q == StPlay) && !pause && (tick_q == TICK_LAST);
  assign note_done = tick_wrap && (dur_q == DUR_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      index_q    <= '0;
      dur_q      <= '0;
      tick_q     <= '0;
      code_q     <= '0;
      note_q     <= '0;
      playing_q  <= 1'b0;
      song_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      dur_q      <= dur_d;
      tick_q     <= tick_d;
      code_q     <= code_d;
      note_q     <= note_d;
      playing_q  <= playing_d;
      song_end_q <= song_end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StFetch: state_d = StLoad;
        StLoad: begin
          if (word_dur == '0) state_d = LOOP ? StFetch : StEnd;
          else                state_d = StPlay;
        end
        StPlay: begin
          if (note_done) state_d = (last_idx && !LOOP) ? StEnd : StFetch;
        end
        StEnd:   state_d = StEnd;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    index_d    = index_q;
    dur_d      = dur_q;
    tick_d     = tick_q;
    code_d     = code_q;
    note_d     = note_q;
    playing_d  = playing_q;
    song_end_d = 1'b0;
    if (start) begin
      index_d   = '0;
      tick_d    = '0;
      note_d    = '0;
      playing_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (word_dur == '0) begin
            note_d     = '0;
            playing_d  = 1'b0;
            song_end_d = 1'b1;
            index_d    = '0;
          end else begin
            code_d    = word_code;
            note_d    = word_code;
            dur_d     = word_dur;
            tick_d    = '0;
            playing_d = 1'b1;
          end
        end
        StPlay: begin
          if (pause) begin
            note_d    = '0;
            playing_d = 1'b0;
          end else begin
            note_d    = code_q;
            playing_d = 1'b1;
            if (tick_wrap) begin
              tick_d = '0;
              dur_d  = dur_q - DUR_W'(1);
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
            // Note stays on through FETCH/LOAD; a full index space ends the song.
            if (note_done) begin
              playing_d = 1'b0;
              if (last_idx) begin
                index_d    = '0;
                note_d     = '0;
                song_end_d = 1'b1;
              end else begin
                index_d = index_q + IDX_W'(1);
              end
            end
          end
        end
        StEnd: begin
          note_d    = '0;
          playing_d = 1'b0;
        end
        default: begin
          playing_d = 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = {select, index_q};
  assign note     = note_q;
  assign playing  = playing_q;
  assign song_end = song_end_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: per-cycle vector table through a scoreboard,
// plus sequences for wrap, LOOP=0 end handling and asynchronous reset.
module tb_music_sequencer;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned DUR_W    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned AW       = IDX_W + 2;
  localparam int unsigned WW       = NOTE_W + DUR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        select = 2'd0, select0 = 2'd0;
  logic              start = 1'b0, start0 = 1'b0;
  logic              pause = 1'b0, pause0 = 1'b0;
  logic [AW-1:0]     mem_addr, mem_addr0;
  logic [WW-1:0]     mem_data, mem_data0;
  logic [NOTE_W-1:0] note, note0;
  logic              playing, playing0, song_end, song_end0;

  logic [WW-1:0] rom [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_data  <= rom[mem_addr];
    mem_data0 <= rom[mem_addr0];
  end

  music_sequencer #(
    .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV), .LOOP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .select(select), .start(start), .pause(pause),
    .mem_addr(mem_addr), .mem_data(mem_data), .note(note), .playing(playing),
    .song_end(song_end)
  );

  music_sequencer #(
    .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV), .LOOP(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .select(select0), .start(start0), .pause(pause0),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .note(note0), .playing(playing0),
    .song_end(song_end0)
  );

  typedef struct {
    int unsigned n;
    logic [1:0]  sel;
    logic        st;
    logic        pa;
    logic [3:0]  note;
    logic        pl;
    logic        se;
    logic [4:0]  addr;
  } vec_t;

  typedef struct {
    logic [3:0] note;
    logic       pl;
    logic       se;
    logic [4:0] addr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;

  int n_cmp = 0;
  int n_fail = 0;

  int pulses, pulse_at, nz_notes, pl_cnt, bad;
  logic [4:0] addr_at_pulse;
  logic [3:0] last_note;
  logic [3:0] obs[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int unsigned n, input logic [1:0] s, input logic st, input logic pa,
                     input logic [3:0] nt, input logic pl, input logic se, input logic [4:0] a);
    vec_t v;
    v.n = n; v.sel = s; v.st = st; v.pa = pa; v.note = nt; v.pl = pl; v.se = se; v.addr = a;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) rom[a] = '0;
    for (int k = 0; k < 8; k++) rom[k] = 8'(((k + 1) << 4) | 1);
    rom[8]  = 8'h31;
    rom[9]  = 8'h41;
    rom[10] = 8'h00;
    rom[16] = 8'h52;
    rom[17] = 8'h91;
    rom[18] = 8'hF0;
    rom[24] = 8'h00;

    // Song 2 from start, loop, paused replay of note 5, then restart into song 1.
    add(1, 2, 1, 0, 0, 0, 0, 5'h10);
    add(1, 2, 0, 0, 0, 0, 0, 5'h10);
    add(8, 2, 0, 0, 5, 1, 0, 5'h10);
    add(1, 2, 0, 0, 5, 0, 0, 5'h11);
    add(1, 2, 0, 0, 5, 0, 0, 5'h11);
    add(4, 2, 0, 0, 9, 1, 0, 5'h11);
    add(1, 2, 0, 0, 9, 0, 0, 5'h12);
    add(1, 2, 0, 0, 9, 0, 0, 5'h12);
    add(1, 2, 0, 0, 0, 0, 1, 5'h10);
    add(1, 2, 0, 0, 0, 0, 0, 5'h10);
    add(4, 2, 0, 0, 5, 1, 0, 5'h10);
    add(7, 2, 0, 1, 0, 0, 0, 5'h10);
    add(4, 2, 0, 0, 5, 1, 0, 5'h10);
    add(1, 2, 0, 0, 5, 0, 0, 5'h11);
    add(1, 2, 0, 0, 5, 0, 0, 5'h11);
    add(1, 2, 0, 0, 9, 1, 0, 5'h11);
    add(1, 1, 1, 0, 0, 0, 0, 5'h08);
    add(1, 1, 0, 0, 0, 0, 0, 5'h08);
    add(4, 1, 0, 0, 3, 1, 0, 5'h08);
    add(1, 1, 0, 0, 3, 0, 0, 5'h09);
    add(1, 1, 0, 0, 3, 0, 0, 5'h09);
    add(4, 1, 0, 0, 4, 1, 0, 5'h09);
    add(1, 1, 0, 0, 4, 0, 0, 5'h0A);
    add(1, 1, 0, 0, 4, 0, 0, 5'h0A);
    add(1, 1, 0, 0, 0, 0, 1, 5'h08);
    add(1, 1, 0, 0, 0, 0, 0, 5'h08);
    add(1, 1, 0, 0, 3, 1, 0, 5'h08);

    @(negedge clk);
    cmp("reset_out", {note, playing, song_end, mem_addr}, {4'd0, 1'b0, 1'b0, 5'h00});
    cmp("reset_out0", {note0, playing0, song_end0}, 6'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("idle_out", {note, playing, song_end}, 6'd0);

    foreach (vecs[i]) begin
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        select = vecs[i].sel;
        start  = vecs[i].st;
        pause  = vecs[i].pa;
        e.note = vecs[i].note; e.pl = vecs[i].pl; e.se = vecs[i].se; e.addr = vecs[i].addr;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        cmp($sformatf("vec%0d.%0d {note,pl,end,addr}", i, k),
            {21'd0, note, playing, song_end, mem_addr}, {21'd0, e.note, e.pl, e.se, e.addr});
      end
    end
    start = 1'b0;
    pause = 1'b0;

    // Asynchronous reset between edges while note 3 is sounding.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("async_reset_out", {note, playing, song_end}, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (note !== 4'd0 || playing !== 1'b0 || mem_addr !== {select, 3'd0}) bad++;
    end
    cmp("post_reset_no_fetch", bad, 0);

    // Song 0 fills all eight words: expect wrap with one song_end, then replay.
    select = 2'd0;
    start  = 1'b1;
    pulses = 0; pulse_at = -1; addr_at_pulse = '0; last_note = '0;
    obs.delete();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (song_end === 1'b1) begin
        pulses++;
        pulse_at = i;
        addr_at_pulse = mem_addr;
      end
      if (note !== last_note && note !== 4'd0) obs.push_back(note);
      last_note = note;
    end
    cmp("wrap_pulses", pulses, 1);
    cmp("wrap_pulse_cycle", pulse_at, 48);
    cmp("wrap_pulse_addr", addr_at_pulse, 5'h00);
    cmp("wrap_note_count_ge9", (obs.size() >= 9) ? 1 : 0, 1);
    for (int k = 0; k < 9 && k < obs.size(); k++)
      cmp($sformatf("wrap_note%0d", k), obs[k], (k == 8) ? 1 : k + 1);

    // LOOP=0 instance: marker as first word stops in END after one pulse.
    select0 = 2'd3;
    start0  = 1'b1;
    pulses = 0; pulse_at = -1; nz_notes = 0; pl_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      if (song_end0 === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
      if (note0 !== 4'd0) nz_notes++;
      if (playing0 !== 1'b0) pl_cnt++;
    end
    cmp("end0_pulses", pulses, 1);
    cmp("end0_pulse_cycle", pulse_at, 2);
    cmp("end0_note_silent", nz_notes, 0);
    cmp("end0_not_playing", pl_cnt, 0);
    cmp("end0_addr", mem_addr0, 5'h18);

    select0 = 2'd2;
    start0  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      start0 = 1'b0;
      if (i == 0) cmp("restart0_addr", mem_addr0, 5'h10);
      if (i == 1) cmp("restart0_note_pre", note0, 4'd0);
      if (i == 2) cmp("restart0_note", {note0, playing0}, {4'd5, 1'b1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
